// File: rtl/uart_mmio_host.sv
// uart_mmio_host: drives a memory-mapped UART peripheral over a simple
// strobe bus. Each bus access is one select cycle followed by one idle
// cycle in which read data is captured. All outputs are registered.
module uart_mmio_host #(
  parameter logic [31:0] TX_TIMEOUT = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cfg_byte_rate,
  input  logic        cfg_load,
  input  logic        tx_valid,
  input  logic [7:0]  tx_byte,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  output logic        rx_parity_err,
  output logic        tx_timeout,
  output logic        bus_select,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [3:0] {
    CFG_RATE  = 4'd0,  CFG_SETUP = 4'd1,  IDLE      = 4'd2,
    TX_DATA   = 4'd3,  TX_GO     = 4'd4,  TX_POLL   = 4'd5,
    TX_CLR    = 4'd6,  RX_FLAGS  = 4'd7,  RX_DATA   = 4'd8,
    RX_CLR    = 4'd9,  RX_REL    = 4'd10
  } state_t;

  // ARM only occurs after reset or when a timeout lands on a select cycle:
  // it is a select-low cycle that precedes the state's own select cycle.
  typedef enum logic [1:0] {
    PH_ARM = 2'd0, PH_SEL = 2'd1, PH_CAP = 2'd2
  } phase_t;

  state_t      r_state, w_state_nxt;
  phase_t      r_phase, w_phase_nxt;
  logic [31:0] r_poll_cnt;
  logic        r_cfg_pend, w_cfg_pend_nxt;
  logic        r_tx_pend, w_tx_pend_nxt;
  logic [7:0]  r_tx_byte, w_tx_byte_nxt;
  logic        r_rx_turn, w_rx_turn_nxt;
  logic        r_rx_par, w_rx_par_nxt;
  logic        r_tx_timeout, w_timeout_nxt;
  logic        r_tx_ready, w_ready_nxt;
  logic        r_rx_valid, w_rx_valid_nxt;
  logic [7:0]  r_rx_byte;
  logic        r_rx_perr;
  logic        r_bus_select, w_sel_nxt;
  logic        r_bus_write, w_write_nxt;
  logic [31:0] r_bus_addr, w_addr_nxt;
  logic [31:0] r_bus_wdata, w_wdata_nxt;
  logic        w_accept, w_cfg_take, w_tx_take;
  logic        w_unused_rdata;

  assign w_unused_rdata = ^bus_rdata[31:8];
  assign w_accept       = tx_valid && r_tx_ready;

  // Next-state, handshake bookkeeping and next bus drive values.
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_timeout_nxt  = r_tx_timeout;
    w_rx_par_nxt   = r_rx_par;
    w_rx_turn_nxt  = r_rx_turn;
    w_rx_valid_nxt = 1'b0;
    w_cfg_take     = 1'b0;
    w_tx_take      = 1'b0;
    w_tx_byte_nxt  = w_accept ? tx_byte : r_tx_byte;
    case (r_state)
      IDLE: begin
        if (r_cfg_pend || cfg_load) begin
          w_state_nxt = CFG_RATE;
          w_phase_nxt = PH_SEL;
          w_cfg_take  = 1'b1;
        end else begin
          w_rx_turn_nxt = !r_rx_turn;
          if (r_rx_turn) begin
            w_state_nxt = RX_FLAGS;
            w_phase_nxt = PH_SEL;
          end else if (r_tx_pend || w_accept) begin
            w_state_nxt = TX_DATA;
            w_phase_nxt = PH_SEL;
            w_tx_take   = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        if (r_phase == PH_ARM) begin
          w_phase_nxt = PH_SEL;
        end else if (r_phase == PH_SEL) begin
          w_phase_nxt = PH_CAP;
        end else begin
          w_phase_nxt = PH_SEL;
          case (r_state)
            CFG_RATE:  w_state_nxt = CFG_SETUP;
            CFG_SETUP: w_state_nxt = IDLE;
            TX_DATA:   w_state_nxt = TX_GO;
            TX_GO:     w_state_nxt = TX_POLL;
            TX_POLL:   w_state_nxt = bus_rdata[0] ? TX_CLR : TX_POLL;
            TX_CLR:    w_state_nxt = IDLE;
            RX_FLAGS: begin
              if (bus_rdata[1]) begin
                w_state_nxt  = RX_DATA;
                w_rx_par_nxt = bus_rdata[2];
              end else begin
                w_state_nxt = IDLE;
              end
            end
            RX_DATA: begin
              w_state_nxt    = RX_CLR;
              w_rx_valid_nxt = 1'b1;
            end
            RX_CLR:    w_state_nxt = RX_REL;
            RX_REL:    w_state_nxt = IDLE;
            default:   w_state_nxt = CFG_RATE;
          endcase
        end
        // A completed poll wins over an expiring budget in the same cycle.
        if ((r_state == TX_POLL) && (r_poll_cnt == TX_TIMEOUT - 32'd1) &&
            !((r_phase == PH_CAP) && bus_rdata[0])) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = TX_CLR;
          w_phase_nxt   = (r_phase == PH_SEL) ? PH_ARM : PH_SEL;
        end else begin
          w_timeout_nxt = r_tx_timeout;
        end
      end
    endcase

    w_cfg_pend_nxt = w_cfg_take ? 1'b0 : (r_cfg_pend || cfg_load);
    w_tx_pend_nxt  = w_tx_take  ? 1'b0 : (r_tx_pend || w_accept);
    w_ready_nxt    = (w_state_nxt == IDLE) && !w_timeout_nxt &&
                     !w_tx_pend_nxt && !w_cfg_pend_nxt;

    w_sel_nxt   = (w_state_nxt != IDLE) && (w_phase_nxt == PH_SEL);
    w_write_nxt = 1'b0;
    w_addr_nxt  = 32'd0;
    w_wdata_nxt = 32'd0;
    if (w_sel_nxt) begin
      case (w_state_nxt)
        CFG_RATE:  begin w_write_nxt = 1'b1; w_addr_nxt = 32'd4; w_wdata_nxt = cfg_byte_rate; end
        CFG_SETUP: begin w_write_nxt = 1'b1; w_addr_nxt = 32'd0; w_wdata_nxt = 32'd0; end
        TX_DATA:   begin w_write_nxt = 1'b1; w_addr_nxt = 32'd2; w_wdata_nxt = {24'd0, w_tx_byte_nxt}; end
        TX_GO:     begin w_write_nxt = 1'b1; w_addr_nxt = 32'd0; w_wdata_nxt = 32'd1; end
        TX_POLL:   begin w_write_nxt = 1'b0; w_addr_nxt = 32'd1; w_wdata_nxt = 32'd0; end
        TX_CLR:    begin w_write_nxt = 1'b1; w_addr_nxt = 32'd0; w_wdata_nxt = 32'd0; end
        RX_FLAGS:  begin w_write_nxt = 1'b0; w_addr_nxt = 32'd1; w_wdata_nxt = 32'd0; end
        RX_DATA:   begin w_write_nxt = 1'b0; w_addr_nxt = 32'd3; w_wdata_nxt = 32'd0; end
        RX_CLR:    begin w_write_nxt = 1'b1; w_addr_nxt = 32'd0; w_wdata_nxt = 32'd8; end
        RX_REL:    begin w_write_nxt = 1'b1; w_addr_nxt = 32'd0; w_wdata_nxt = 32'd0; end
        default:   begin w_write_nxt = 1'b0; w_addr_nxt = 32'd0; w_wdata_nxt = 32'd0; end
      endcase
    end else begin
      w_write_nxt = 1'b0;
      w_addr_nxt  = 32'd0;
      w_wdata_nxt = 32'd0;
    end
  end

  // State, bookkeeping and registered outputs; reset abandons any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= CFG_RATE;
      r_phase      <= PH_ARM;
      r_poll_cnt   <= 32'd0;
      r_cfg_pend   <= 1'b0;
      r_tx_pend    <= 1'b0;
      r_tx_byte    <= 8'd0;
      r_rx_turn    <= 1'b0;
      r_rx_par     <= 1'b0;
      r_tx_timeout <= 1'b0;
      r_tx_ready   <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_byte    <= 8'd0;
      r_rx_perr    <= 1'b0;
      r_bus_select <= 1'b0;
      r_bus_write  <= 1'b0;
      r_bus_addr   <= 32'd0;
      r_bus_wdata  <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_poll_cnt   <= (r_state == TX_POLL) ? (r_poll_cnt + 32'd1) : 32'd0;
      r_cfg_pend   <= w_cfg_pend_nxt;
      r_tx_pend    <= w_tx_pend_nxt;
      r_tx_byte    <= w_tx_byte_nxt;
      r_rx_turn    <= w_rx_turn_nxt;
      r_rx_par     <= w_rx_par_nxt;
      r_tx_timeout <= w_timeout_nxt;
      r_tx_ready   <= w_ready_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_rx_byte    <= w_rx_valid_nxt ? bus_rdata[7:0] : r_rx_byte;
      r_rx_perr    <= w_rx_valid_nxt ? r_rx_par : r_rx_perr;
      r_bus_select <= w_sel_nxt;
      r_bus_write  <= w_write_nxt;
      r_bus_addr   <= w_addr_nxt;
      r_bus_wdata  <= w_wdata_nxt;
    end
  end

  assign tx_ready      = r_tx_ready;
  assign rx_valid      = r_rx_valid;
  assign rx_byte       = r_rx_byte;
  assign rx_parity_err = r_rx_perr;
  assign tx_timeout    = r_tx_timeout;
  assign bus_select    = r_bus_select;
  assign bus_write     = r_bus_write;
  assign bus_addr      = r_bus_addr;
  assign bus_wdata     = r_bus_wdata;

endmodule

// File: tb/tb_uart_mmio_host.sv
// tb_uart_mmio_host: directed bench with a small UART register model that
// answers reads and logs every bus access for later inspection.
module tb_uart_mmio_host;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cfg_byte_rate = 32'd868;
  logic        cfg_load = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_byte = 8'd0;
  logic        tx_ready, rx_valid, rx_parity_err, tx_timeout;
  logic [7:0]  rx_byte;
  logic        bus_select, bus_write;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  uart_mmio_host #(.TX_TIMEOUT(32'd10)) dut (
    .clk(clk), .rst(rst), .cfg_byte_rate(cfg_byte_rate), .cfg_load(cfg_load),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_parity_err(rx_parity_err),
    .tx_timeout(tx_timeout), .bus_select(bus_select), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic [7:0]  b;
    int          polls;
    logic [31:0] exp_wdata;
  } tx_vec_t;

  acc_t acc_log[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   proto_err = 0;
  int   proto_err2 = 0;
  logic prev_sel = 1'b0;

  // peripheral model state
  logic        tx_active_m = 1'b0;
  int          poll_seen_m = 0;
  int          target_polls = 1;
  int          rx_req_cnt = 0;
  int          rx_clr_cnt = 0;
  logic        rx_par_m = 1'b0;
  logic [7:0]  rx_data_m = 8'd0;
  logic [31:0] rdata_r = 32'd0;

  assign bus_rdata = rdata_r;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 32'd1)
      v = {29'd0, rx_par_m, (rx_req_cnt != rx_clr_cnt),
           (tx_active_m && (poll_seen_m + 1 >= target_polls))};
    else if (a == 32'd3)
      v = {24'd0, rx_data_m};
    return v;
  endfunction

  // Peripheral model: logs accesses, returns read data during cycle N+1.
  always @(posedge clk) begin
    prev_sel <= bus_select;
    if (bus_select && prev_sel) proto_err <= proto_err + 1;
    if (!rst) begin
      tx_active_m <= 1'b0;
    end else if (bus_select) begin
      if (bus_write) begin
        acc_log.push_back(acc_t'({1'b1, bus_addr, bus_wdata}));
        if (bus_addr == 32'd0 && bus_wdata == 32'd1) begin
          tx_active_m <= 1'b1;
          poll_seen_m <= 0;
        end else if (bus_addr == 32'd0 && bus_wdata == 32'd0) begin
          tx_active_m <= 1'b0;
        end else if (bus_addr == 32'd0 && bus_wdata == 32'd8) begin
          rx_clr_cnt <= rx_clr_cnt + 1;
        end
      end else begin
        acc_log.push_back(acc_t'({1'b0, bus_addr, model_rd(bus_addr)}));
        rdata_r <= model_rd(bus_addr);
        if (bus_addr == 32'd1 && tx_active_m) poll_seen_m <= poll_seen_m + 1;
      end
    end
  end

  // Idle bus must carry zero address, data and write.
  always @(negedge clk) begin
    if (!bus_select && (bus_addr != 32'd0 || bus_wdata != 32'd0 || bus_write))
      proto_err2 <= proto_err2 + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic acc_t get_acc(input int i);
    if (i >= 0 && i < acc_log.size()) return acc_log[i];
    else return acc_t'({1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
  endfunction

  function automatic int find_acc(input int from, input logic wr, input logic [31:0] a,
                                  input logic [31:0] d, input logic use_d);
    for (int i = (from < 0 ? 0 : from); i < acc_log.size(); i++)
      if (acc_log[i].wr == wr && acc_log[i].addr == a && (!use_d || acc_log[i].data == d))
        return i;
    return -1;
  endfunction

  task automatic check_acc(input string name, input int idx, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
    acc_t e;
    e = get_acc(idx);
    check($sformatf("%s.wr", name), 32'(e.wr), 32'(wr));
    check($sformatf("%s.addr", name), e.addr, a);
    check($sformatf("%s.data", name), e.data, d);
  endtask

  task automatic wait_ready(input string name, input int bound);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s.ready", name), 32'(tx_ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready("send", 60);
    tx_valid = 1'b1;
    tx_byte  = b;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic do_rx(input logic [7:0] d, input logic par, input logic [31:0] exp_flags);
    int mark, n, r3;
    mark = acc_log.size();
    rx_data_m = d;
    rx_par_m  = par;
    rx_req_cnt++;
    n = 0;
    while (rx_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rx.valid", 32'(rx_valid), 32'd1);
    check("rx.byte", 32'(rx_byte), 32'(d));
    check("rx.parity", 32'(rx_parity_err), 32'(par));
    @(negedge clk);
    check("rx.pulse_end", 32'(rx_valid), 32'd0);
    repeat (6) @(negedge clk);
    check("rx.hold", 32'(rx_byte), 32'(d));
    r3 = find_acc(mark, 1'b0, 32'd3, 32'd0, 1'b0);
    check_acc("rx.flags", r3 - 1, 1'b0, 32'd1, exp_flags);
    check_acc("rx.data", r3, 1'b0, 32'd3, {24'd0, d});
    check_acc("rx.clr", r3 + 1, 1'b1, 32'd0, 32'd8);
    check_acc("rx.rel", r3 + 2, 1'b1, 32'd0, 32'd0);
  endtask

  initial begin
    tx_vec_t vecs[4];
    int mark, g, i, n, c;
    logic ready_seen, to_lost;

    vecs[0] = '{8'hA5, 3, 32'h0000_00A5};
    vecs[1] = '{8'h00, 1, 32'h0000_0000};
    vecs[2] = '{8'hFF, 2, 32'h0000_00FF};
    vecs[3] = '{8'h3C, 4, 32'h0000_003C};

    // reset state
    repeat (3) @(negedge clk);
    check("rst.flags", 32'({tx_ready, rx_valid, rx_parity_err, tx_timeout,
                            bus_select, bus_write}), 32'd0);
    check("rst.rx_byte", 32'(rx_byte), 32'd0);
    check("rst.addr", bus_addr, 32'd0);
    check("rst.wdata", bus_wdata, 32'd0);

    // configuration after reset release
    mark = acc_log.size();
    rst = 1'b1;
    wait_ready("boot", 40);
    check("boot.count", 32'(acc_log.size() - mark), 32'd2);
    check_acc("boot.rate", mark, 1'b1, 32'd4, 32'd868);
    check_acc("boot.setup", mark + 1, 1'b1, 32'd0, 32'd0);

    // transmit vectors
    for (int k = 0; k < 4; k++) begin
      mark = acc_log.size();
      target_polls = vecs[k].polls;
      send(vecs[k].b);
      wait_ready("tx.done", 80);
      g = find_acc(mark, 1'b1, 32'd2, 32'd0, 1'b0);
      check_acc($sformatf("tx%0d.data", k), g, 1'b1, 32'd2, vecs[k].exp_wdata);
      check_acc($sformatf("tx%0d.go", k), g + 1, 1'b1, 32'd0, 32'd1);
      i = g + 2;
      while (get_acc(i).wr == 1'b0 && get_acc(i).addr == 32'd1) i++;
      check($sformatf("tx%0d.polls", k), 32'(i - (g + 2)), 32'(vecs[k].polls));
      check_acc($sformatf("tx%0d.clr", k), i, 1'b1, 32'd0, 32'd0);
    end

    // receive sequences
    do_rx(8'h3C, 1'b1, 32'h6);
    do_rx(8'h81, 1'b0, 32'h2);

    // cfg_load while polling a transmit
    mark = acc_log.size();
    target_polls = 4;
    cfg_byte_rate = 32'd434;
    send(8'h5A);
    n = 0;
    while (!(bus_select && !bus_write && bus_addr == 32'd1 && tx_active_m) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("cfg.in_poll", 32'(bus_select && tx_active_m), 32'd1);
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    wait_ready("cfg", 80);
    g = find_acc(mark, 1'b1, 32'd0, 32'd1, 1'b1);
    c = find_acc(g + 1, 1'b1, 32'd0, 32'd0, 1'b1);
    check("cfg.polls", 32'(c - g - 1), 32'd4);
    check_acc("cfg.rate", c + 1, 1'b1, 32'd4, 32'd434);
    check_acc("cfg.setup", c + 2, 1'b1, 32'd0, 32'd0);
    check("cfg.count", 32'(acc_log.size()), 32'(c + 3));

    // reset during the TX_DATA access
    send(8'hC3);
    n = 0;
    while (!(bus_select && bus_write && bus_addr == 32'd2) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rrst.in_txdata", 32'(bus_select && bus_addr == 32'd2), 32'd1);
    rst = 1'b0;
    #1;
    check("rrst.sel", 32'(bus_select), 32'd0);
    check("rrst.addr", bus_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    mark = acc_log.size();
    rst = 1'b1;
    wait_ready("rrst", 40);
    check("rrst.count", 32'(acc_log.size() - mark), 32'd2);
    check_acc("rrst.rate", mark, 1'b1, 32'd4, 32'd434);
    check_acc("rrst.setup", mark + 1, 1'b1, 32'd0, 32'd0);

    // transmit timeout with the sent flag never set
    mark = acc_log.size();
    target_polls = 1000;
    send(8'h11);
    n = 0;
    while (tx_timeout !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to.flag", 32'(tx_timeout), 32'd1);
    check("to.clr_sel", 32'({bus_select, bus_write}), 32'd3);
    check("to.clr_addr", bus_addr, 32'd0);
    check("to.clr_wdata", bus_wdata, 32'd0);
    ready_seen = 1'b0;
    to_lost = 1'b0;
    tx_valid = 1'b1;
    tx_byte = 8'h77;
    repeat (20) begin
      @(negedge clk);
      ready_seen = ready_seen | tx_ready;
      to_lost = to_lost | !tx_timeout;
    end
    tx_valid = 1'b0;
    check("to.ready_low", 32'(ready_seen), 32'd0);
    check("to.sticky", 32'(to_lost), 32'd0);
    g = find_acc(mark, 1'b1, 32'd0, 32'd1, 1'b1);
    i = g + 1;
    while (get_acc(i).wr == 1'b0 && get_acc(i).addr == 32'd1) i++;
    check("to.polls", 32'(i - g - 1), 32'd5);
    check_acc("to.clr", i, 1'b1, 32'd0, 32'd0);
    check("to.no_tx", 32'(find_acc(i + 1, 1'b1, 32'd2, 32'd0, 1'b0)), 32'hFFFF_FFFF);

    check("bus.protocol", 32'(proto_err + proto_err2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_mmio_host.md
UART_MMIO_HOST -- requirements
Module: uart_mmio_host

Interface
REQ-001 SHALL have parameter TX_TIMEOUT, default 32'd1_000_000: maximum cycles spent polling for transmit completion.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cfg_byte_rate  input  32  bit-period value programmed into the UART peripheral.
REQ-005 SHALL have port cfg_load  input  1  single-cycle pulse that requests reprogramming of the rate register.
REQ-006 SHALL have port tx_valid  input  1  transmit byte offered.
REQ-007 SHALL have port tx_byte  input  8  byte to transmit.
REQ-008 SHALL have port tx_ready  output  1  host can accept a transmit byte.
REQ-009 SHALL have port rx_valid  output  1  single-cycle pulse: a received byte is on rx_byte.
REQ-010 SHALL have port rx_byte  output  8  received byte.
REQ-011 SHALL have port rx_parity_err  output  1  parity error flag, qualified by rx_valid.
REQ-012 SHALL have port tx_timeout  output  1  sticky flag: a transmit poll exceeded TX_TIMEOUT.
REQ-013 SHALL have port bus_select  output  1  peripheral access strobe.
REQ-014 SHALL have port bus_write  output  1  1 = write, 0 = read.
REQ-015 SHALL have port bus_addr  output  32  peripheral register address.
REQ-016 SHALL have port bus_wdata  output  32  write data.
REQ-017 SHALL have port bus_rdata  input  32  peripheral read data.

Function
REQ-018 SHALL use this peripheral register map: 0 SETUP (bit0 send, bit3 rx-flag clear); 1 FLAGS (bit0 tx_sent, bit1 rx_flag, bit2 parity error); 2 TX_DATA; 3 RX_DATA; 4 BYTE_RATE.
REQ-019 SHALL perform every access as bus_select high for exactly 1 cycle (cycle N), with addr, write and wdata stable in that cycle, followed by bus_select low in cycle N+1.
REQ-020 SHALL capture bus_rdata for reads at the end of cycle N+1; the minimum spacing between accesses is therefore 2 cycles.
REQ-021 SHALL drive bus_addr, bus_wdata and bus_write to 0 whenever bus_select is low.
REQ-022 SHALL implement these FSM states: CFG_RATE, CFG_SETUP, IDLE, TX_DATA, TX_GO, TX_POLL, TX_CLR, RX_FLAGS, RX_DATA, RX_CLR, RX_REL.
REQ-023 SHALL leave reset in CFG_RATE: write cfg_byte_rate to address 4, then CFG_SETUP writes 0 to address 0, then IDLE.
REQ-024 SHALL assert tx_ready only in IDLE, and only while tx_timeout is 0.
REQ-025 SHALL, in IDLE, give priority in this order: pending cfg_load, then the periodic rx poll (RX_FLAGS, every other IDLE visit), then tx_valid&&tx_ready.
REQ-026 SHALL latch a cfg_load pulse that arrives outside IDLE and service it on the next IDLE entry (CFG_RATE, then CFG_SETUP).
REQ-027 SHALL complete the transmit sequence as follows: when tx_valid&&tx_ready, latch tx_byte; TX_DATA writes {24'b0, tx_byte} to address 2; TX_GO writes 1 to address 0.
REQ-028 SHALL, in TX_POLL, read address 1 repeatedly until bit0 = 1, then go to TX_CLR, which writes 0 to address 0 and returns to IDLE.
REQ-029 SHALL count TX_POLL cycles and, when the count reaches TX_TIMEOUT, set tx_timeout and go to TX_CLR.
REQ-030 SHALL clear tx_timeout only by reset.
REQ-031 SHALL complete the receive sequence as follows: RX_FLAGS reads address 1; if bit1 = 0, return to IDLE; else save bit2 and go to RX_DATA.
REQ-032 SHALL, in RX_DATA, read address 3 and, in the cycle after capture, drive rx_byte = bus_rdata[7:0], rx_parity_err = saved bit2 and pulse rx_valid.
REQ-033 SHALL then write 32'h8 to address 0 in RX_CLR and 0 to address 0 in RX_REL, and return to IDLE.
REQ-034 SHALL hold a tx_valid that arrives during an rx sequence; it is accepted on return to IDLE, and no byte is lost.
REQ-035 SHALL hold rx_byte at its last value between rx_valid pulses.
REQ-036 SHALL, because rx_valid has no backpressure, require that the consumer accept rx_valid unconditionally.

Reset
REQ-037 SHALL, when rst is low, immediately force: state CFG_RATE, all outputs 0 (tx_ready, rx_valid, rx_byte, rx_parity_err, tx_timeout, bus_*), poll counter 0, pending cfg_load cleared.
REQ-038 SHALL, on a reset asserted mid-sequence, abandon the sequence without a bus access and, after release, restart from CFG_RATE.

Verification
REQ-039 SHALL cover: release reset with cfg_byte_rate = 868 -> writes (addr 4, 868) then (addr 0, 0); tx_ready rises after the second access.
REQ-040 SHALL cover: tx_byte = 8'hA5 with tx_valid; model FLAGS bit0 = 1 on the 3rd poll -> writes (2, 32'hA5), (0, 1), 3 reads of addr 1, then (0, 0); tx_ready returns.
REQ-041 SHALL cover: model FLAGS = 32'h6, RX_DATA = 32'h3C -> rx_valid pulse for 1 cycle with rx_byte = 8'h3C and rx_parity_err = 1, followed by writes (0, 8) then (0, 0).
REQ-042 SHALL cover: TX_TIMEOUT = 10 with FLAGS always 0 -> tx_timeout = 1 after 10 poll cycles, a write (0, 0) is issued, and tx_ready stays 0.
REQ-043 SHALL cover: cfg_load = 1 during TX_POLL with the rate changed to 434 -> after TX_CLR, writes (4, 434) then (0, 0) before any new tx.
REQ-044 SHALL cover: rst low during TX_DATA -> bus_select = 0 in the same cycle; after release, the sequence restarts at CFG_RATE.
